// File: rtl/mips_controller_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller.
//   state_t    4-bit FSM state encodings (FETCH1 = 0 .. ADDIWR = 14; 15 unused)
//   OP_*       opcode constants (instr[31:26])
//   FN_*       R-type funct constants (instr[5:0])
//   ALUOP_*    aluop codes passed to alu_decoder
//   ALU_*      alucontrol codes driven to the ALU
//   ctrl_t     per-state Moore control word
//   state_ctrl maps a state to its control word
// Build option: CTRL_ADDI_EN gives ADDIEX/ADDIWR a control word; without it
// they decode to all zeros (they are unreachable in that build anyway).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    if (s == FETCH1 || s == FETCH2 || s == FETCH3 || s == FETCH4) begin
      c.memread = 1'b1;
      c.alusrcb = 2'b01;
      c.pcwrite = 1'b1;
    end
    case (s)
      FETCH1:  c.irwrite = 4'b0001;
      FETCH2:  c.irwrite = 4'b0010;
      FETCH3:  c.irwrite = 4'b0100;
      FETCH4:  c.irwrite = 4'b1000;
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALUOP_SUB;
        c.branch   = 1'b1;
        c.pcsource = 2'b01;
      end
      JEX: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
`ifdef CTRL_ADDI_EN
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWR:  c.regwrite = 1'b1;
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_if.sv
// mips_controller_if: controller <-> datapath signal bundle.
//   master: controller side (consumes op/funct/zero, drives all controls)
//   slave:  datapath side
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic [3:0] irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic [1:0] pcsource;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, alusrcb, iord, irwrite, memtoreg,
           regdst, regwrite, pcsource, pcen, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, alusrcb, iord, irwrite, memtoreg,
           regdst, regwrite, pcsource, pcen, alucontrol, state
  );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// alu_decoder: combinational ALU operation select.
//   aluop      in  2  00=add, 01=sub, 10=use funct
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation; unknown funct falls back to add
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// mips_controller: multicycle control FSM for the 8-bit MIPS core.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; forces every output to 0 while high
//   bus    mips_controller_if.master (op/funct/zero in; datapath controls,
//          pcen, alucontrol and debug state out)
// Build option: CTRL_ADDI_EN adds the ADDIEX/ADDIWR path for op 001000.
//
//   state   | meaning
//   FETCH1-4| read one instruction byte each, PC += 1
//   DECODE  | branch target into aluout, dispatch on op
//   MEMADR  | A + imm8 address for LB/SB
//   LBRD    | memory read at aluout
//   LBWR    | memory data to rt
//   SBWR    | memory write at aluout
//   RTYPEEX | A op B per funct
//   RTYPEWR | aluout to rd
//   BEQEX   | A - B, take branch if zero
//   JEX     | PC <- jump target
//   ADDIEX  | A + imm8 (CTRL_ADDI_EN)
//   ADDIWR  | aluout to rt (CTRL_ADDI_EN)
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mips_controller_if.master bus
);

  state_t     state_q;
  ctrl_t      ctrl_q;
  logic [2:0] alu_ctl;

  function automatic state_t next_state(state_t s, logic [5:0] op);
    state_t n;
    n = FETCH1;
    case (s)
      FETCH1:  n = FETCH2;
      FETCH2:  n = FETCH3;
      FETCH3:  n = FETCH4;
      FETCH4:  n = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: n = MEMADR;
          OP_RTYPE:     n = RTYPEEX;
          OP_BEQ:       n = BEQEX;
          OP_J:         n = JEX;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      n = ADDIEX;
`endif
          default:      n = FETCH1;
        endcase
      end
      // op only ever holds LB or SB here, so SB is the single discriminator
      MEMADR:  n = (op == OP_SB) ? SBWR : LBRD;
      LBRD:    n = LBWR;
      RTYPEEX: n = RTYPEWR;
`ifdef CTRL_ADDI_EN
      ADDIEX:  n = ADDIWR;
`endif
      default: n = FETCH1;
    endcase
    return n;
  endfunction

  // The control word is registered alongside the state it belongs to, so the
  // outputs are glitch-free Moore decodes of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH1;
      ctrl_q  <= state_ctrl(FETCH1);
    end else begin
      state_q <= next_state(state_q, bus.op);
      ctrl_q  <= state_ctrl(next_state(state_q, bus.op));
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_q.aluop),
    .funct      (bus.funct),
    .alucontrol (alu_ctl)
  );

  // reset gates the outputs combinationally so an aborted instruction cannot
  // strobe regwrite/memwrite in the cycle reset is raised.
  assign bus.memread    = ~reset & ctrl_q.memread;
  assign bus.memwrite   = ~reset & ctrl_q.memwrite;
  assign bus.alusrca    = ~reset & ctrl_q.alusrca;
  assign bus.alusrcb    = reset ? 2'b00 : ctrl_q.alusrcb;
  assign bus.iord       = ~reset & ctrl_q.iord;
  assign bus.irwrite    = reset ? 4'b0000 : ctrl_q.irwrite;
  assign bus.memtoreg   = ~reset & ctrl_q.memtoreg;
  assign bus.regdst     = ~reset & ctrl_q.regdst;
  assign bus.regwrite   = ~reset & ctrl_q.regwrite;
  assign bus.pcsource   = reset ? 2'b00 : ctrl_q.pcsource;
  assign bus.pcen       = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero));
  assign bus.alucontrol = reset ? 3'b000 : alu_ctl;
  assign bus.state      = reset ? 4'b0000 : state_q;

endmodule
